// File: rtl/imem_sync.sv
// Loadable, registered-read instruction memory for the fetch stage.
// Run-time programming port, per-word written tracking, fault-coded fetch.
module imem_sync #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] NOP = '0,
  localparam int IW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_en,
  input  logic              prog_we,
  input  logic [IW-1:0]     prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_pc,
  input  logic              stall,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic [1:0]        fault_code,
  output logic              busy,
  output logic [IW:0]       prog_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PROG = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  localparam logic [1:0] F_OK  = 2'b00;
  localparam logic [1:0] F_MIS = 2'b01;
  localparam logic [1:0] F_OOR = 2'b10;
  localparam logic [1:0] F_UNW = 2'b11;

  localparam logic [IW:0] DEPTH_W = (IW+1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  wr_q;
  logic [IW:0]       cnt_q;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic [1:0]        fault_q, fault_d;

  logic          addr_ok;
  logic          idx_ok;
  logic          wr_en;
  logic          fetch_go;
  logic          misal;
  logic          hit;
  logic [IW-1:0] rd_idx;

  // Full-range indices make the bound checks vacuous.
  if (DEPTH == (1 << IW)) begin : g_addr_full
    assign addr_ok = 1'b1;
  end else begin : g_addr_cmp
    assign addr_ok = {1'b0, prog_addr} < DEPTH_W;
  end

  if (DEPTH == (1 << (ADDR_W-2))) begin : g_idx_full
    assign idx_ok = 1'b1;
  end else begin : g_idx_cmp
    localparam logic [ADDR_W-2:0] DEPTH_PC = (ADDR_W-1)'(DEPTH);
    logic [ADDR_W-3:0] pc_idx;
    assign pc_idx = fetch_pc[ADDR_W-1:2];
    assign idx_ok = {1'b0, pc_idx} < DEPTH_PC;
  end

  assign rd_idx   = fetch_pc[IW+1:2];
  assign misal    = |fetch_pc[1:0];
  assign hit      = wr_q[rd_idx];
  assign wr_en    = (state_q == S_PROG) && prog_we && addr_ok;
  assign fetch_go = (state_q == S_RUN) && fetch_req
                    && !prog_en && !stall;

  always_comb begin
    state_d = state_q;
    if (prog_en) begin
      state_d = S_PROG;
    end else if (state_q == S_PROG) begin
      state_d = S_RUN;
    end
  end

  always_comb begin
    instr_d = instr_q;
    fault_d = fault_q;
    valid_d = 1'b0;
    if (stall) begin
      valid_d = valid_q;
    end else if (fetch_go) begin
      valid_d = 1'b1;
      instr_d = NOP;
      unique case (1'b1)
        misal: fault_d = F_MIS;
        !misal && !idx_ok: fault_d = F_OOR;
        !misal && idx_ok && !hit: fault_d = F_UNW;
        default: begin
          fault_d = F_OK;
          instr_d = mem[rd_idx];
        end
      endcase
    end
  end

  // Array contents survive reset; only the written bits are cleared.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      cnt_q   <= '0;
      instr_q <= NOP;
      valid_q <= 1'b0;
      fault_q <= F_OK;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      if (wr_en) begin
        wr_q[prog_addr] <= 1'b1;
        if (cnt_q != DEPTH_W) begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign fault_code  = fault_q;
  assign busy        = (state_q == S_PROG);
  assign prog_count  = cnt_q;

endmodule

// File: tb/tb_imem_sync.sv
// Bench for imem_sync: DEPTH=64 and DEPTH=32 instances against
// a behavioural model, plus directed literal checks.
module tb_imem_sync;

  logic        clk;
  logic        rst_n;
  logic        prog_en;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [31:0] prog_data;
  logic        fetch_req;
  logic [7:0]  fetch_pc;
  logic        stall;

  logic [31:0] a_instr, b_instr;
  logic        a_valid, b_valid;
  logic [1:0]  a_fault, b_fault;
  logic        a_busy, b_busy;
  logic [6:0]  a_cnt;
  logic [5:0]  b_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 0;

  imem_sync u64 (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en),
    .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .fetch_req(fetch_req),
    .fetch_pc(fetch_pc), .stall(stall),
    .instr(a_instr), .instr_valid(a_valid),
    .fault_code(a_fault), .busy(a_busy),
    .prog_count(a_cnt)
  );

  imem_sync #(.DEPTH(32)) u32 (
    .clk(clk), .rst_n(rst_n), .prog_en(prog_en),
    .prog_we(prog_we), .prog_addr(prog_addr[4:0]),
    .prog_data(prog_data), .fetch_req(fetch_req),
    .fetch_pc(fetch_pc), .stall(stall),
    .instr(b_instr), .instr_valid(b_valid),
    .fault_code(b_fault), .busy(b_busy),
    .prog_count(b_cnt)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  // Model: 0 = idle, 1 = programming, 2 = running
  int          mdep [2] = '{64, 32};
  logic [31:0] mmem [2][64];
  bit          mwr  [2][64];
  int          mcnt [2];
  int          mmode[2];
  logic [31:0] minstr[2];
  bit          mval [2];
  int          mflt [2];

  function automatic void mreset(int k);
    mmode[k] = 0;
    mcnt[k] = 0;
    minstr[k] = 32'h0;
    mval[k] = 0;
    mflt[k] = 0;
    for (int i = 0; i < 64; i++) mwr[k][i] = 0;
  endfunction

  function automatic void mstep(int k);
    int a;
    int idx;
    a = (k == 0) ? int'(prog_addr) : int'(prog_addr[4:0]);
    if (!stall) begin
      if (mmode[k] == 2 && fetch_req && !prog_en) begin
        mval[k] = 1;
        minstr[k] = 32'h0;
        idx = int'(fetch_pc) / 4;
        if (int'(fetch_pc) % 4 != 0) mflt[k] = 1;
        else if (idx >= mdep[k]) mflt[k] = 2;
        else if (!mwr[k][idx]) mflt[k] = 3;
        else begin
          mflt[k] = 0;
          minstr[k] = mmem[k][idx];
        end
      end else begin
        mval[k] = 0;
      end
    end
    if (mmode[k] == 1 && prog_we && a < mdep[k]) begin
      mmem[k][a] = prog_data;
      mwr[k][a] = 1;
      if (mcnt[k] < mdep[k]) mcnt[k]++;
    end
    if (prog_en) mmode[k] = 1;
    else if (mmode[k] == 1) mmode[k] = 2;
  endfunction

  always @(posedge clk) if (rst_n) begin
    mstep(0);
    mstep(1);
  end

  always @(negedge rst_n) begin
    mreset(0);
    mreset(1);
  end

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (cmp_en) begin
    chk("a.instr", a_instr, minstr[0]);
    chk("a.valid", 32'(a_valid), 32'(mval[0]));
    chk("a.fault", 32'(a_fault), 32'(mflt[0]));
    chk("a.busy", 32'(a_busy), 32'(mmode[0] == 1));
    chk("a.count", 32'(a_cnt), 32'(mcnt[0]));
    chk("b.instr", b_instr, minstr[1]);
    chk("b.valid", 32'(b_valid), 32'(mval[1]));
    chk("b.fault", 32'(b_fault), 32'(mflt[1]));
    chk("b.busy", 32'(b_busy), 32'(mmode[1] == 1));
    chk("b.count", 32'(b_cnt), 32'(mcnt[1]));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(int a, logic [31:0] d);
    prog_addr = 6'(a);
    prog_data = d;
    step();
  endtask

  task automatic fetch(logic [7:0] pc);
    fetch_pc = pc;
    step();
  endtask

  initial begin
    rst_n = 0;
    prog_en = 0;
    prog_we = 0;
    prog_addr = 0;
    prog_data = 0;
    fetch_req = 0;
    fetch_pc = 0;
    stall = 0;
    mreset(0);
    mreset(1);
    repeat (2) step();
    rst_n = 1;
    cmp_en = 1;
    chk("rst.instr", a_instr, 32'h0);
    chk("rst.valid", 32'(a_valid), 32'h0);
    chk("rst.busy", 32'(a_busy), 32'h0);
    chk("rst.count", 32'(a_cnt), 32'h0);

    fetch_req = 1;
    step();
    step();
    chk("idle.valid", 32'(a_valid), 32'h0);
    chk("idle.busy", 32'(a_busy), 32'h0);
    fetch_req = 0;

    prog_en = 1;
    step();
    chk("prog.busy", 32'(a_busy), 32'h1);
    prog_we = 1;
    wr(0, 32'h014B4820);
    wr(1, 32'h01AE6022);
    wr(2, 32'h21490001);
    prog_we = 0;
    prog_en = 0;
    step();
    chk("run.busy", 32'(a_busy), 32'h0);
    chk("prog.count", 32'(a_cnt), 32'd3);

    fetch_req = 1;
    fetch(8'h00);
    chk("f0.instr", a_instr, 32'h014B4820);
    chk("f0.valid", 32'(a_valid), 32'h1);
    fetch(8'h04);
    chk("f4.instr", a_instr, 32'h01AE6022);
    fetch(8'h08);
    chk("f8.instr", a_instr, 32'h21490001);
    chk("f8.fault", 32'(a_fault), 32'h0);
    fetch(8'h06);
    chk("mis.fault", 32'(a_fault), 32'h1);
    chk("mis.instr", a_instr, 32'h0);
    fetch(8'hFC);
    chk("unw.fault", 32'(a_fault), 32'h3);
    fetch(8'h80);
    chk("oor32.fault", 32'(b_fault), 32'h2);
    chk("oor64.fault", 32'(a_fault), 32'h3);

    fetch(8'h04);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      fetch(8'($urandom));
      chk("stall.valid", 32'(a_valid), 32'h1);
      chk("stall.instr", a_instr, 32'h01AE6022);
    end
    stall = 0;
    fetch_req = 0;
    step();
    chk("rel.valid", 32'(a_valid), 32'h0);
    chk("rel.instr", a_instr, 32'h01AE6022);

    prog_en = 1;
    step();
    prog_we = 1;
    for (int i = 0; i < 69; i++) wr(i % 64, $urandom);
    chk("sat64.count", 32'(a_cnt), 32'd64);
    chk("sat32.count", 32'(b_cnt), 32'd32);

    #2 rst_n = 0;
    step();
    chk("mrst.count", 32'(a_cnt), 32'h0);
    chk("mrst.busy", 32'(a_busy), 32'h0);
    chk("mrst.valid", 32'(a_valid), 32'h0);
    prog_we = 0;
    prog_en = 0;
    rst_n = 1;
    step();
    prog_en = 1;
    step();
    prog_we = 1;
    wr(1, 32'hCAFE0001);
    prog_we = 0;
    prog_en = 0;
    step();
    fetch_req = 1;
    fetch(8'h00);
    chk("rp.fault", 32'(a_fault), 32'h3);
    chk("rp.instr", a_instr, 32'h0);
    fetch(8'h04);
    chk("rp1.instr", a_instr, 32'hCAFE0001);

    for (int c = 0; c < 3000; c++) begin
      prog_en = ($urandom_range(99) < 6);
      prog_we = ($urandom_range(99) < 60);
      prog_addr = 6'($urandom);
      prog_data = $urandom;
      fetch_req = ($urandom_range(99) < 70);
      stall = ($urandom_range(99) < 15);
      if ($urandom_range(1)) fetch_pc = 8'($urandom_range(63) * 4);
      else fetch_pc = 8'($urandom);
      if ($urandom_range(999) < 3) begin
        #2 rst_n = 0;
        step();
        rst_n = 1;
      end else begin
        step();
      end
    end

    cmp_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
